// File: rtl/asu_bist_pkg.sv
// ============================================================================
// asu_bist_pkg: shared constants, FSM encoding and ASU golden model.
// Rev 1.0
// ============================================================================
`default_nettype none

package asu_bist_pkg;

  localparam logic        MODE_ADD     = 1'b1;
  localparam logic        MODE_SHIFT   = 1'b0;
  localparam logic [15:0] LFSR_DEFAULT = 16'hACE1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DRIVE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CHECK = 3'd3,
    ST_FIN   = 3'd4
  } state_t;

  // Result is {carry, out}; shift mode zero-fills and never produces a carry.
  function automatic logic [8:0] asu_golden(input logic [7:0] x,
                                            input logic [7:0] y,
                                            input logic       mode);
    if (mode == MODE_ADD)
      return {1'b0, x} + {1'b0, y};
    else
      return {1'b0, x << y[2:0]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/asu_bist_lfsr.sv
// ============================================================================
// asu_bist_lfsr: 16-bit Fibonacci LFSR (taps 16,14,13,11), load/step enables.
// Rev 1.0
// ============================================================================
`default_nettype none

module asu_bist_lfsr
  import asu_bist_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        step,
  output logic [15:0] value
);

  logic feedback;

  assign feedback = value[15] ^ value[13] ^ value[12] ^ value[10];

  always_ff @(posedge clk) begin
    if (rst)
      value <= LFSR_DEFAULT;
    else if (load)
      value <= load_val;
    else if (step)
      value <= {value[14:0], feedback};
  end

endmodule

`default_nettype wire

// File: rtl/asu_bist_ctrl.sv
// ============================================================================
// asu_bist_ctrl: on-chip pattern driver and checker for the 8-bit ASU.
// First-failure log ports exist only when ASU_BIST_LOG_EN is defined. Rev 1.0
// ============================================================================
`default_nettype none

module asu_bist_ctrl
  import asu_bist_pkg::*;
#(
  parameter int LAT   = 1,
  parameter int PAT_W = 8,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PAT_W-1:0] num_patterns,
  input  logic [15:0]      seed,
  output logic [7:0]       asu_x,
  output logic [7:0]       asu_y,
  output logic             asu_mode,
  input  logic             asu_carry,
  input  logic [7:0]       asu_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt
`ifdef ASU_BIST_LOG_EN
  ,
  output logic             fail_vld,
  output logic [PAT_W-1:0] fail_idx,
  output logic [8:0]       fail_got,
  output logic [8:0]       fail_exp
`endif
);

  localparam int               CNT_W     = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [CNT_W-1:0] LAST_WAIT = (LAT > 0) ? CNT_W'(LAT - 1) : '0;

  state_t           state;
  state_t           state_nxt;
  logic [PAT_W-1:0] num_lat;
  logic [PAT_W-1:0] idx;
  logic [CNT_W-1:0] wait_cnt;
  logic [15:0]      lfsr;
  logic [15:0]      seed_eff;
  logic             lfsr_load;
  logic             lfsr_step;
  logic             in_pattern;
  logic [8:0]       exp_val;
  logic [8:0]       got_val;
  logic             mismatch;

  assign seed_eff = (seed == 16'h0000) ? LFSR_DEFAULT : seed;

  asu_bist_lfsr u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .load     (lfsr_load),
    .load_val (seed_eff),
    .step     (lfsr_step),
    .value    (lfsr)
  );

  // Operands come straight from the LFSR, which only moves at the end of
  // CHECK, so they stay stable for the whole pattern. Even patterns shift.
  assign in_pattern = (state == ST_DRIVE) || (state == ST_WAIT) || (state == ST_CHECK);
  assign asu_x      = in_pattern ? lfsr[7:0]  : 8'h00;
  assign asu_y      = in_pattern ? lfsr[15:8] : 8'h00;
  assign asu_mode   = in_pattern ? (idx[0] ? MODE_ADD : MODE_SHIFT) : 1'b0;
  assign busy       = in_pattern;

  assign exp_val  = asu_golden(asu_x, asu_y, asu_mode);
  assign got_val  = {asu_carry, asu_out};
  assign mismatch = (state == ST_CHECK) && (got_val !== exp_val);

  always_comb begin
    state_nxt = state;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          lfsr_load = 1'b1;
          state_nxt = (num_patterns == '0) ? ST_FIN : ST_DRIVE;
        end
      end
      ST_DRIVE: state_nxt = (LAT == 0) ? ST_CHECK : ST_WAIT;
      ST_WAIT: begin
        if (wait_cnt == LAST_WAIT)
          state_nxt = ST_CHECK;
      end
      ST_CHECK: begin
        lfsr_step = 1'b1;
        state_nxt = (idx == num_lat - PAT_W'(1)) ? ST_FIN : ST_DRIVE;
      end
      ST_FIN:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      num_lat  <= '0;
      idx      <= '0;
      wait_cnt <= '0;
      err_cnt  <= '0;
      done     <= 1'b0;
      pass     <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            num_lat <= num_patterns;
            idx     <= '0;
            err_cnt <= '0;
            pass    <= 1'b0;
          end
        end
        ST_DRIVE: wait_cnt <= '0;
        ST_WAIT:  wait_cnt <= wait_cnt + CNT_W'(1);
        ST_CHECK: begin
          if (mismatch && (err_cnt != '1))
            err_cnt <= err_cnt + ERR_W'(1);
          idx <= idx + PAT_W'(1);
        end
        ST_FIN: begin
          done <= 1'b1;
          pass <= (err_cnt == '0);
        end
        default: ;
      endcase
    end
  end

`ifdef ASU_BIST_LOG_EN
  always_ff @(posedge clk) begin
    if (rst || ((state == ST_IDLE) && start)) begin
      fail_vld <= 1'b0;
      fail_idx <= '0;
      fail_got <= '0;
      fail_exp <= '0;
    end else if (mismatch && !fail_vld) begin
      fail_vld <= 1'b1;
      fail_idx <= idx;
      fail_got <= got_val;
      fail_exp <= exp_val;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_asu_bist_ctrl.sv
// ============================================================================
// tb_asu_bist_ctrl: directed bench with operand scoreboard for asu_bist_ctrl.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_asu_bist_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_a = 1'b0;
  logic        start_b = 1'b0;
  logic [7:0]  num = 8'd0;
  logic [15:0] seed = 16'h0000;
  logic        inv_a = 1'b0;
  logic        inv_b = 1'b0;

  logic [7:0]  x_a, y_a, out_a, x_b, y_b, out_b;
  logic        m_a, m_b, carry_a, carry_b;
  logic        busy_a, done_a, pass_a, busy_b, done_b, pass_b;
  logic [7:0]  err_a;
  logic [3:0]  err_b;
  logic [8:0]  res_a = 9'h000;
  logic [8:0]  res_b;
`ifdef ASU_BIST_LOG_EN
  logic        fvld_a, fvld_b;
  logic [7:0]  fidx_a, fidx_b;
  logic [8:0]  fgot_a, fexp_a, fgot_b, fexp_b;
`endif

  always #5 clk = ~clk;

  function automatic logic [8:0] ref_asu(input logic [7:0] x, input logic [7:0] y, input logic m);
    logic [7:0] sh;
    sh = x << y[2:0];
    return m ? ({1'b0, x} + {1'b0, y}) : {1'b0, sh};
  endfunction

  function automatic logic [15:0] lfsr_nx(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  // Instance A: registered ASU (LAT=1). Instance B: combinational ASU, 4-bit errors.
  always @(posedge clk) res_a <= ref_asu(x_a, y_a, m_a) ^ {inv_a, 8'h00};
  assign {carry_a, out_a} = res_a;
  assign res_b = ref_asu(x_b, y_b, m_b) ^ {inv_b, 8'h00};
  assign {carry_b, out_b} = res_b;

  asu_bist_ctrl #(.LAT(1), .PAT_W(8), .ERR_W(8)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .num_patterns(num), .seed(seed),
    .asu_x(x_a), .asu_y(y_a), .asu_mode(m_a), .asu_carry(carry_a), .asu_out(out_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_cnt(err_a)
`ifdef ASU_BIST_LOG_EN
    , .fail_vld(fvld_a), .fail_idx(fidx_a), .fail_got(fgot_a), .fail_exp(fexp_a)
`endif
  );

  asu_bist_ctrl #(.LAT(0), .PAT_W(8), .ERR_W(4)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .num_patterns(num), .seed(seed),
    .asu_x(x_b), .asu_y(y_b), .asu_mode(m_b), .asu_carry(carry_b), .asu_out(out_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_cnt(err_b)
`ifdef ASU_BIST_LOG_EN
    , .fail_vld(fvld_b), .fail_idx(fidx_b), .fail_got(fgot_b), .fail_exp(fexp_b)
`endif
  );

  logic        sel = 1'b0;
  int          lat = 1;
  logic [16:0] obs_pat;
  logic        obs_busy, obs_done, obs_pass;
  logic [7:0]  obs_err;

  always_comb begin
    if (sel) begin
      obs_pat  = {m_b, y_b, x_b};
      obs_busy = busy_b;
      obs_done = done_b;
      obs_pass = pass_b;
      obs_err  = {4'h0, err_b};
    end else begin
      obs_pat  = {m_a, y_a, x_a};
      obs_busy = busy_a;
      obs_done = done_a;
      obs_pass = pass_a;
      obs_err  = err_a;
    end
  end

  int          errors = 0;
  int          checks = 0;
  logic [16:0] sb[$];
  logic [16:0] first_pat;
  logic [16:0] exp_pat;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Queue the operand sequence the run must present, then pulse start.
  task automatic start_run(input int n, input logic [15:0] sd);
    logic [15:0] s;
    s = (sd == 16'h0000) ? 16'hACE1 : sd;
    first_pat = {1'b0, s[15:8], s[7:0]};
    sb.delete();
    for (int k = 0; k < n; k++) begin
      sb.push_back({(k % 2 == 1), s[15:8], s[7:0]});
      s = lfsr_nx(s);
    end
    num  = n[7:0];
    seed = sd;
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    tick();
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic check_patterns(input int cnt);
    for (int j = 0; j < cnt; j++) begin
      if (sb.size() == 0) begin
        check("scoreboard_underflow", 32'd0, 32'd1);
        return;
      end
      exp_pat = sb.pop_front();
      check("pattern", {15'd0, obs_pat}, {15'd0, exp_pat});
      repeat (lat + 2) tick();
    end
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (!obs_done && k < 20) begin
      tick();
      k++;
    end
    check("done_latency", k, 32'd1);
    check("busy_at_done", {31'd0, obs_busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) tick();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      sel = (i == 1);
      #1;
      check("rst_busy", {31'd0, obs_busy}, 32'd0);
      check("rst_done", {31'd0, obs_done}, 32'd0);
      check("rst_pass", {31'd0, obs_pass}, 32'd0);
      check("rst_err", {24'd0, obs_err}, 32'd0);
      check("rst_ports", {15'd0, obs_pat}, 32'd0);
    end

    // 1: combinational ASU, single shift pattern 0x81 << 3
    sel = 1'b1; lat = 0; inv_b = 1'b0;
    start_run(1, 16'h0381);
    check("t1_operands", {15'd0, obs_pat}, 32'h0_0381);
    check("t1_golden", {23'd0, ref_asu(8'h81, 8'h03, 1'b0)}, 32'h008);
    check_patterns(1);
    wait_done();
    check("t1_pass", {31'd0, obs_pass}, 32'd1);
    check("t1_err", {24'd0, obs_err}, 32'd0);
    tick();
    check("t1_done_one_cycle", {31'd0, obs_done}, 32'd0);

    // 2: registered ASU, 100 good patterns
    sel = 1'b0; lat = 1; inv_a = 1'b0;
    start_run(100, 16'hBEEF);
    check_patterns(100);
    wait_done();
    check("t2_pass", {31'd0, obs_pass}, 32'd1);
    check("t2_err", {24'd0, obs_err}, 32'd0);
    tick();

    // 3: carry inverted, every pattern fails
    inv_a = 1'b1;
    start_run(10, 16'h0000);
    check_patterns(10);
    wait_done();
    check("t3_pass", {31'd0, obs_pass}, 32'd0);
    check("t3_err", {24'd0, obs_err}, 32'd10);
`ifdef ASU_BIST_LOG_EN
    check("t3_fail_vld", {31'd0, fvld_a}, 32'd1);
    check("t3_fail_idx", {24'd0, fidx_a}, 32'd0);
    check("t3_fail_exp", {23'd0, fexp_a}, {23'd0, ref_asu(first_pat[7:0], first_pat[15:8], 1'b0)});
    check("t3_fail_got", {23'd0, fgot_a},
          {23'd0, ref_asu(first_pat[7:0], first_pat[15:8], 1'b0) ^ 9'h100});
`endif
    tick();

    // 4: 4-bit error counter saturates
    sel = 1'b1; lat = 0; inv_b = 1'b1;
    start_run(20, 16'h5A5A);
    check_patterns(20);
    wait_done();
    check("t4_pass", {31'd0, obs_pass}, 32'd0);
    check("t4_err_sat", {24'd0, obs_err}, 32'd15);
    tick();

    // 5: zero-length run
    sel = 1'b0; lat = 1; inv_a = 1'b0;
    start_run(0, 16'h1111);
    check("t5_ports_idle", {15'd0, obs_pat}, 32'd0);
    check("t5_pass_cleared", {31'd0, obs_pass}, 32'd0);
    wait_done();
    check("t5_pass", {31'd0, obs_pass}, 32'd1);
    check("t5_ports_done", {15'd0, obs_pat}, 32'd0);
    tick();

    // 6: start while busy is ignored, reset mid-run at pattern 5
    inv_a = 1'b1;
    start_run(20, 16'h1234);
    check_patterns(3);
    exp_pat = sb.pop_front();
    check("t6_pattern3", {15'd0, obs_pat}, {15'd0, exp_pat});
    num = 8'd1; seed = 16'hFFFF; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (lat + 1) tick();
    check_patterns(1);
    exp_pat = sb.pop_front();
    check("t6_pattern5", {15'd0, obs_pat}, {15'd0, exp_pat});
    check("t6_err_before_rst", {24'd0, obs_err}, 32'd5);
    check("t6_busy_before_rst", {31'd0, obs_busy}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_rst_busy", {31'd0, obs_busy}, 32'd0);
    check("t6_rst_err", {24'd0, obs_err}, 32'd0);
    check("t6_rst_ports", {15'd0, obs_pat}, 32'd0);
    check("t6_rst_done", {31'd0, obs_done}, 32'd0);
    check("t6_rst_pass", {31'd0, obs_pass}, 32'd0);
    sb.delete();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
